// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential word fetch, in-order response queue,
// decode handshake, and redirect flush with discard of in-flight responses.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int PW = $clog2(QDEPTH);
    localparam logic [PW+1:0] DEPTH = QDEPTH[PW+1:0];

    typedef logic [PW:0] ptr_t;

    logic [31:0]       fetch_pc;
    ptr_t              alloc_ptr;
    ptr_t              fill_ptr;
    ptr_t              head_ptr;
    ptr_t              discard_cnt;
    logic [31:0]       pc_mem    [QDEPTH];
    logic [31:0]       instr_mem [QDEPTH];
    logic [QDEPTH-1:0] filled;

    logic [PW-1:0] alloc_idx;
    logic [PW-1:0] fill_idx;
    logic [PW-1:0] head_idx;
    ptr_t          used;
    ptr_t          outstanding;
    logic [PW+1:0] budget;
    logic          req_fire;
    logic          dec_fire;
    logic          resp_keep;
    logic          resp_drop;
    logic          unused_pc_bits;

    assign alloc_idx   = alloc_ptr[PW-1:0];
    assign fill_idx    = fill_ptr[PW-1:0];
    assign head_idx    = head_ptr[PW-1:0];
    assign used        = alloc_ptr - head_ptr;
    assign outstanding = alloc_ptr - fill_ptr;

    // Queue slots plus responses still owed to a flushed stream.
    assign budget = {1'b0, used} + {1'b0, discard_cnt};

    assign imem_req_valid = rst_n && !redirect_valid && (budget < DEPTH);
    assign imem_req_addr  = {fetch_pc[31:2], 2'b00};

    assign dec_valid = filled[head_idx] && (head_ptr != fill_ptr)
                       && !redirect_valid;
    assign dec_instr = instr_mem[head_idx];
    assign dec_pc    = pc_mem[head_idx];

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign dec_fire  = dec_valid && dec_ready;
    assign resp_drop = imem_resp_valid && (discard_cnt != '0);
    assign resp_keep = imem_resp_valid && (discard_cnt == '0);

    assign unused_pc_bits = ^redirect_pc[1:0];

    // Fetch PC, queue pointers and discard accounting; redirect wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= {RESET_PC[31:2], 2'b00};
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            head_ptr    <= '0;
            discard_cnt <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= {redirect_pc[31:2], 2'b00};
            fill_ptr    <= alloc_ptr;
            head_ptr    <= alloc_ptr;
            discard_cnt <= discard_cnt + outstanding
                           - ptr_t'(imem_resp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc  <= fetch_pc + 32'd4;
                alloc_ptr <= alloc_ptr + ptr_t'(1);
            end
            if (resp_drop) begin
                discard_cnt <= discard_cnt - ptr_t'(1);
            end
            if (resp_keep) begin
                fill_ptr <= fill_ptr + ptr_t'(1);
            end
            if (dec_fire) begin
                head_ptr <= head_ptr + ptr_t'(1);
            end
        end
    end

    // Queue storage: pc at allocation, instr and filled bit at response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filled <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (redirect_valid) begin
            filled <= '0;
        end else begin
            if (req_fire) begin
                pc_mem[alloc_idx] <= fetch_pc;
                filled[alloc_idx] <= 1'b0;
            end
            if (resp_keep) begin
                instr_mem[fill_idx] <= imem_resp_data;
                filled[fill_idx]    <= 1'b1;
            end
            if (dec_fire) begin
                filled[head_idx] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a fixed-latency in-order
// memory model that answers each request with addr ^ 32'hA5A5_0000.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 1;
    int cyc     = 0;
    int inflight;

    logic [31:0] mq_addr [$];
    int          mq_cyc  [$];
    logic [31:0] acc_log [$];
    logic [31:0] dpc_log [$];
    logic [31:0] dins_log[$];

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .QDEPTH  (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // A response must always have an accepted request ahead of it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 0;
        end else begin
            assert (!(imem_resp_valid && inflight == 0))
                else $error("protocol: response with nothing outstanding");
            inflight <= inflight
                        + ((imem_req_valid && imem_req_ready) ? 1 : 0)
                        - (imem_resp_valid ? 1 : 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        #1;
        if (imem_req_valid && imem_req_ready) begin
            mq_addr.push_back(imem_req_addr);
            mq_cyc.push_back(cyc);
            acc_log.push_back(imem_req_addr);
        end
        if (dec_valid && dec_ready) begin
            dpc_log.push_back(dec_pc);
            dins_log.push_back(dec_instr);
        end
        @(posedge clk);
        #1;
        cyc++;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        if (mq_addr.size() > 0 && mq_cyc[0] + lat <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mq_addr[0] ^ 32'hA5A5_0000;
            void'(mq_addr.pop_front());
            void'(mq_cyc.pop_front());
        end
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        dec_ready       = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        mq_addr.delete();
        mq_cyc.delete();
        acc_log.delete();
        dpc_log.delete();
        dins_log.delete();
        #1;
        n_tests++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_req_valid: got %b want 0", imem_req_valid);
        end
        n_tests++;
        if (dec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_dec_valid: got %b want 0", dec_valid);
        end
        n_tests++;
        if (dec_instr !== 32'h0 || dec_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_dec_data: got instr %h pc %h want 0 0",
                     dec_instr, dec_pc);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_first_req: got v=%b a=%h want v=1 a=0",
                     imem_req_valid, imem_req_addr);
        end
        n_tests++;
        if (dec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dec_idle: got %b want 0", dec_valid);
        end
    endtask

    task automatic test_stream();
        logic [31:0] want;
        do_reset();
        lat       = 1;
        dec_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            want = 32'(4 * c);
            n_tests++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== want) begin
                n_fail++;
                $display("FAIL stream_addr c%0d: got v=%b a=%h want v=1 a=%h",
                         c, imem_req_valid, imem_req_addr, want);
            end
            if (c < 2) begin
                n_tests++;
                if (dec_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stream_early c%0d: got %b want 0",
                             c, dec_valid);
                end
            end else begin
                want = 32'(4 * (c - 2));
                n_tests++;
                if (dec_valid !== 1'b1 || dec_pc !== want
                    || dec_instr !== (want ^ 32'hA5A5_0000)) begin
                    n_fail++;
                    $display("FAIL stream_dec c%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                             c, dec_valid, dec_pc, dec_instr,
                             want, want ^ 32'hA5A5_0000);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] got;
        do_reset();
        lat       = 1;
        dec_ready = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        #1;
        n_tests++;
        if (acc_log.size() != 4) begin
            n_fail++;
            $display("FAIL bp_accept_count: got %0d want 4", acc_log.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < acc_log.size()) ? acc_log[i] : 32'hDEAD_BEEF;
            n_tests++;
            if (got !== 32'(4 * i)) begin
                n_fail++;
                $display("FAIL bp_accept_addr %0d: got %h want %h",
                         i, got, 32'(4 * i));
            end
        end
        n_tests++;
        if (imem_req_valid !== 1'b0 || dec_valid !== 1'b1 || dec_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL bp_full: got req=%b dv=%b pc=%h want 0 1 0",
                     imem_req_valid, dec_valid, dec_pc);
        end
        dec_ready = 1'b1;
        #1;
        n_tests++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full_deq_req: got %b want 0", imem_req_valid);
        end
        tick();
        #1;
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL bp_resume: got v=%b a=%h want v=1 a=10",
                     imem_req_valid, imem_req_addr);
        end
        for (int c = 0; c < 8; c++) tick();
        n_tests++;
        if (dpc_log.size() < 5) begin
            n_fail++;
            $display("FAIL bp_drain_count: got %0d want >=5", dpc_log.size());
        end
        for (int i = 0; i < 5; i++) begin
            got = (i < dpc_log.size()) ? dpc_log[i] : 32'hDEAD_BEEF;
            n_tests++;
            if (got !== 32'(4 * i)) begin
                n_fail++;
                $display("FAIL bp_drain_pc %0d: got %h want %h",
                         i, got, 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect_flush();
        do_reset();
        lat       = 3;
        dec_ready = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1000;
        #1;
        n_tests++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_req_blocked: got %b want 0", imem_req_valid);
        end
        tick();
        redirect_valid = 1'b0;
        for (int c = 3; c < 12; c++) begin
            #1;
            if (c == 6) begin
                n_tests++;
                if (dec_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL flush_no_stale: got %b want 0", dec_valid);
                end
            end
            if (c == 7) begin
                n_tests++;
                if (dec_valid !== 1'b1 || dec_pc !== 32'h1000
                    || dec_instr !== 32'hA5A5_1000) begin
                    n_fail++;
                    $display("FAIL flush_first: got v=%b pc=%h i=%h want 1 1000 a5a51000",
                             dec_valid, dec_pc, dec_instr);
                end
            end
            tick();
        end
        n_tests++;
        if (dpc_log.size() < 2 || dpc_log[0] !== 32'h1000
            || dpc_log[1] !== 32'h1004) begin
            n_fail++;
            $display("FAIL flush_order: got n=%0d want pcs 1000,1004 first",
                     dpc_log.size());
        end
        n_tests++;
        if (acc_log.size() < 3 || acc_log[2] !== 32'h1000) begin
            n_fail++;
            $display("FAIL flush_req_addr: got n=%0d want third req 1000",
                     acc_log.size());
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        lat            = 1;
        dec_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2003;
        tick();
        redirect_valid = 1'b0;
        #1;
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h2000) begin
            n_fail++;
            $display("FAIL misalign_addr: got v=%b a=%h want 1 2000",
                     imem_req_valid, imem_req_addr);
        end
        tick();
        tick();
        #1;
        n_tests++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h2000) begin
            n_fail++;
            $display("FAIL misalign_pc: got v=%b pc=%h want 1 2000",
                     dec_valid, dec_pc);
        end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        lat            = 1;
        dec_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        n_tests++;
        if (imem_req_addr !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_addr_top: got %h want fffffffc", imem_req_addr);
        end
        tick();
        #1;
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_addr_zero: got v=%b a=%h want 1 0",
                     imem_req_valid, imem_req_addr);
        end
        tick();
        #1;
        n_tests++;
        if (dec_pc !== 32'hFFFF_FFFC || dec_instr !== 32'h5A5A_FFFC) begin
            n_fail++;
            $display("FAIL wrap_dec_top: got pc=%h i=%h want fffffffc 5a5afffc",
                     dec_pc, dec_instr);
        end
        tick();
        #1;
        n_tests++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_dec_zero: got v=%b pc=%h want 1 0",
                     dec_valid, dec_pc);
        end
    endtask

    task automatic test_req_stall();
        do_reset();
        lat       = 1;
        dec_ready = 1'b1;
        for (int c = 0; c < 16; c++) tick();
        imem_req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_tests++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin
                n_fail++;
                $display("FAIL stall_hold %0d: got v=%b a=%h want 1 40",
                         k, imem_req_valid, imem_req_addr);
            end
            tick();
        end
        imem_req_ready = 1'b1;
        tick();
        #1;
        n_tests++;
        if (acc_log.size() != 17 || acc_log[16] !== 32'h40) begin
            n_fail++;
            $display("FAIL stall_accept: got n=%0d want 17 ending at 40",
                     acc_log.size());
        end
        n_tests++;
        if (imem_req_addr !== 32'h44) begin
            n_fail++;
            $display("FAIL stall_advance: got %h want 44", imem_req_addr);
        end
    endtask

    task automatic test_redirect_collision();
        do_reset();
        lat       = 2;
        dec_ready = 1'b1;
        tick();
        tick();
        tick();
        #1;
        n_tests++;
        if (dec_valid !== 1'b1 || imem_resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL coll_setup: got dv=%b rv=%b want 1 1",
                     dec_valid, imem_resp_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
        #1;
        n_tests++;
        if (dec_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL coll_gate: got dv=%b rq=%b want 0 0",
                     dec_valid, imem_req_valid);
        end
        tick();
        redirect_valid = 1'b0;
        n_tests++;
        if (dpc_log.size() != 0) begin
            n_fail++;
            $display("FAIL coll_not_consumed: got %0d want 0", dpc_log.size());
        end
        n_tests++;
        if (dut.discard_cnt !== 3'd1) begin
            n_fail++;
            $display("FAIL coll_discard: got %0d want 1", dut.discard_cnt);
        end
        for (int c = 0; c < 8; c++) tick();
        n_tests++;
        if (dpc_log.size() < 1 || dpc_log[0] !== 32'h3000) begin
            n_fail++;
            $display("FAIL coll_restart: got n=%0d want first pc 3000",
                     dpc_log.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        lat       = 3;
        dec_ready = 1'b1;
        tick();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0500;
        #1;
        n_tests++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gate: got %b want 0", imem_req_valid);
        end
        tick();
        redirect_pc = 32'h0000_0600;
        tick();
        redirect_valid = 1'b0;
        n_tests++;
        if (dut.discard_cnt !== 3'd1) begin
            n_fail++;
            $display("FAIL b2b_discard: got %0d want 1", dut.discard_cnt);
        end
        for (int c = 0; c < 8; c++) tick();
        n_tests++;
        if (acc_log.size() < 4 || acc_log[3] !== 32'h600) begin
            n_fail++;
            $display("FAIL b2b_req: got n=%0d want fourth req 600",
                     acc_log.size());
        end
        n_tests++;
        if (dpc_log.size() < 1 || dpc_log[0] !== 32'h600) begin
            n_fail++;
            $display("FAIL b2b_dec: got n=%0d want first pc 600",
                     dpc_log.size());
        end
        do_reset();
        #1;
        n_tests++;
        if (imem_req_addr !== 32'h0 || dec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_restart: got a=%h dv=%b want 0 0",
                     imem_req_addr, dec_valid);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_misaligned();
        test_pc_wrap();
        test_req_stall();
        test_redirect_collision();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
